// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2, minimum 1 bit, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned k;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter steering NREQ requesters onto one FIFO write port.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATAW    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*DATAW-1:0] i_req_data,
    input  logic [NREQ-1:0]       i_req_last,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_wr_en,
    output logic [DATAW-1:0]      o_wr_data,
    input  logic                  i_wr_full,
    output logic [NREQ-1:0]       o_grant
);

    localparam int IDXW = clog2(NREQ);
    localparam int CW   = clog2(MAXBURST + 1);

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
    localparam logic [CW-1:0]   CAP_MINUS = CW'(MAXBURST - 1);

    arb_state_e      state_q;
    logic [IDXW-1:0] rr_ptr_q;
    logic [IDXW-1:0] rr_ptr_d;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] grant_q;
    logic [IDXW-1:0] gidx_q;

    logic [NREQ-1:0] pick_grant;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    logic in_burst;
    logic accept;
    logic cap_hit;
    logic release_w;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Handshake is combinational so a full FIFO blocks the same cycle it asserts.
    always_comb begin
        in_burst  = (state_q == BURST);
        accept    = in_burst & i_req_valid[gidx_q] & ~i_wr_full;
        cap_hit   = (cnt_q == CAP_MINUS);
        release_w = accept & (i_req_last[gidx_q] | cap_hit);
        rr_ptr_d  = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
    end

    always_comb begin
        o_req_ready = (in_burst && !i_wr_full) ? grant_q : '0;
        o_wr_en     = accept;
        o_wr_data   = i_req_data[gidx_q*DATAW +: DATAW];
        o_grant     = grant_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= BURST;
                        grant_q <= pick_grant;
                        gidx_q  <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                BURST: begin
                    if (release_w) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        cnt_q    <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule
